// File: rtl/div_clk_monitor.sv
// Period/lock/stall monitor for a divided clock sampled as data in the clk domain.
// Optional DIV_MON_STICKY_EN adds lost_lock_out, a sticky flag set whenever lock is lost.
module div_clk_monitor #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned EXP_RATIO = 4,
  parameter int unsigned TOL       = 0,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             reset_al_in,
  input  logic             div_clk_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid_out,
  output logic             locked_out,
  output logic             stall_out
`ifdef DIV_MON_STICKY_EN
  ,
  output logic             lost_lock_out
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    STALL  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   EXP_W   = (CNT_W+1)'(EXP_RATIO);
  localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             stall_q, stall_d;
  logic [CNT_W:0]   period_w;
  logic [CNT_W:0]   diff;
  logic             match;
  logic             timeout;

  assign rise = s2_q & ~s3_q;

  always_comb begin
    period_w = {1'b0, cnt_q} + (CNT_W+1)'(1);
    diff     = (period_w >= EXP_W) ? (period_w - EXP_W) : (EXP_W - period_w);
    match    = (diff <= TOL_W);
    // rise takes priority over the timeout in the same cycle
    timeout  = (cnt_q == TO_LAST) && !rise;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    match_cnt_d = match_cnt_q;
    period_d    = period_q;
    valid_d     = 1'b0;

    if (rise) begin
      cnt_d = '0;
    end else if (state_q != STALL) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = ACQ;
        end else if (timeout) begin
          state_d     = STALL;
          match_cnt_d = '0;
        end
      end
      ACQ: begin
        if (rise) begin
          period_d = period_w[CNT_W-1:0];
          valid_d  = 1'b1;
          if (match) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_q + 4'd1 == LOCK_N) state_d = LOCKED;
          end else begin
            match_cnt_d = '0;
          end
        end else if (timeout) begin
          state_d     = STALL;
          match_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (rise) begin
          period_d = period_w[CNT_W-1:0];
          valid_d  = 1'b1;
          if (!match) begin
            state_d     = ACQ;
            match_cnt_d = '0;
          end
        end else if (timeout) begin
          state_d     = STALL;
          match_cnt_d = '0;
        end
      end
      STALL: begin
        // interval spanning a stall is stale, so nothing is reported
        if (rise) state_d = ACQ;
      end
      default: state_d = IDLE;
    endcase

    locked_d = (state_d == LOCKED);
    stall_d  = (state_d == STALL);
  end

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      match_cnt_q <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      s1_q        <= div_clk_in;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_cnt_q <= match_cnt_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      stall_q     <= stall_d;
    end
  end

  assign period_out       = period_q;
  assign period_valid_out = valid_q;
  assign locked_out       = locked_q;
  assign stall_out        = stall_q;

`ifdef DIV_MON_STICKY_EN
  logic lost_lock_q, lost_lock_d;

  always_comb begin
    lost_lock_d = lost_lock_q | ((state_q == LOCKED) && (state_d != LOCKED));
  end

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) lost_lock_q <= 1'b0;
    else              lost_lock_q <= lost_lock_d;
  end

  assign lost_lock_out = lost_lock_q;
`endif

endmodule
